// File: rtl/reg_alloc_unit.sv
// Register-block allocator: per-warp lookup table of physical register blocks,
// one block allocated or released per cycle, with a free-register counter.
module reg_alloc_unit #(
  parameter  int NUM_WARPS      = 8,
  parameter  int NUM_BLOCKS     = 16,
  parameter  int REGS_PER_BLOCK = 2,
  parameter  int LUT_DEPTH      = 4,
  parameter  int SWW            = 8,
  localparam int WW             = $clog2(NUM_WARPS),
  localparam int BW             = $clog2(NUM_BLOCKS),
  localparam int LW             = $clog2(LUT_DEPTH),
  localparam int AW             = $clog2(NUM_BLOCKS*REGS_PER_BLOCK+1),
  localparam int NW             = $clog2(LUT_DEPTH*REGS_PER_BLOCK+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           alloc_valid,
  output logic           alloc_ready,
  input  logic [WW-1:0]  alloc_hw_warp,
  input  logic [SWW-1:0] alloc_sw_warp,
  input  logic [NW-1:0]  alloc_nreq,
  output logic           alloc_done,
  output logic           alloc_fail,
  input  logic           exit_valid,
  output logic           exit_ready,
  input  logic [WW-1:0]  exit_warp,
  output logic           exit_done,
  input  logic [WW-1:0]  lk_warp,
  input  logic [LW-1:0]  lk_lblk,
  output logic [BW-1:0]  lk_pblk,
  output logic           lk_hit,
  output logic [SWW-1:0] lk_sw_warp,
  output logic [AW-1:0]  avail_regs
);

  localparam int NBW = NW + 1;

  typedef enum logic [1:0] {IDLE, ALLOC, DEALLOC} state_e;

  state_e               state_q, state_d;
  logic [NUM_BLOCKS-1:0] mt_q, mt_d;
  logic [LUT_DEPTH-1:0] lut_v_q [NUM_WARPS];
  logic [LUT_DEPTH-1:0] lut_v_d [NUM_WARPS];
  logic [BW-1:0]        lut_p_q [NUM_WARPS][LUT_DEPTH];
  logic [BW-1:0]        lut_p_d [NUM_WARPS][LUT_DEPTH];
  logic [NUM_WARPS-1:0] alloc_q, alloc_d;
  logic [SWW-1:0]       sw_q [NUM_WARPS];
  logic [SWW-1:0]       sw_d [NUM_WARPS];
  logic [AW-1:0]        avail_q, avail_d;
  logic [WW-1:0]        warp_q, warp_d;
  logic [NBW-1:0]       nblk_q, nblk_d;
  logic [LW-1:0]        k_q, k_d;
  logic                 alloc_done_q, alloc_done_d;
  logic                 alloc_fail_q, alloc_fail_d;
  logic                 exit_done_q, exit_done_d;

  logic [NBW-1:0]       nblk_c;
  logic [BW-1:0]        free_idx;
  logic                 free_found;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mt_q    <= '0;
      alloc_q <= '0;
      avail_q <= AW'(NUM_BLOCKS*REGS_PER_BLOCK);
      warp_q  <= '0;
      nblk_q  <= '0;
      k_q     <= '0;
      alloc_done_q <= 1'b0;
      alloc_fail_q <= 1'b0;
      exit_done_q  <= 1'b0;
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        lut_v_q[w] <= '0;
        sw_q[w]    <= '0;
        for (int unsigned l = 0; l < LUT_DEPTH; l++) lut_p_q[w][l] <= '0;
      end
    end else begin
      state_q <= state_d;
      mt_q    <= mt_d;
      lut_v_q <= lut_v_d;
      lut_p_q <= lut_p_d;
      alloc_q <= alloc_d;
      sw_q    <= sw_d;
      avail_q <= avail_d;
      warp_q  <= warp_d;
      nblk_q  <= nblk_d;
      k_q     <= k_d;
      alloc_done_q <= alloc_done_d;
      alloc_fail_q <= alloc_fail_d;
      exit_done_q  <= exit_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    lut_v_d = lut_v_q;
    lut_p_d = lut_p_q;
    alloc_d = alloc_q;
    sw_d    = sw_q;
    avail_d = avail_q;
    warp_d  = warp_q;
    nblk_d  = nblk_q;
    k_d     = k_q;
    alloc_done_d = 1'b0;
    alloc_fail_d = 1'b0;
    exit_done_d  = 1'b0;

    nblk_c = NBW'((int'(alloc_nreq) + REGS_PER_BLOCK - 1) / REGS_PER_BLOCK);

    free_idx   = '0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
      if (!mt_q[i] && !free_found) begin
        free_idx   = BW'(i);
        free_found = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        // Exit wins over a simultaneous allocation request.
        if (exit_valid) begin
          warp_d  = exit_warp;
          k_d     = '0;
          state_d = DEALLOC;
        end else if (alloc_valid) begin
          if (nblk_c == '0) begin
            alloc_done_d = 1'b1;
          end else if (int'(nblk_c) > LUT_DEPTH ||
                       int'(nblk_c) * REGS_PER_BLOCK > int'(avail_q) ||
                       alloc_q[alloc_hw_warp]) begin
            alloc_fail_d = 1'b1;
          end else begin
            warp_d                = alloc_hw_warp;
            nblk_d                = nblk_c;
            sw_d[alloc_hw_warp]   = alloc_sw_warp;
            alloc_d[alloc_hw_warp] = 1'b1;
            k_d                   = '0;
            state_d               = ALLOC;
          end
        end
      end
      ALLOC: begin
        mt_d[free_idx]          = 1'b1;
        lut_v_d[warp_q][k_q]    = 1'b1;
        lut_p_d[warp_q][k_q]    = free_idx;
        k_d                     = k_q + LW'(1);
        avail_d                 = avail_q - AW'(REGS_PER_BLOCK);
        if (int'(k_q) == int'(nblk_q) - 1) begin
          state_d      = IDLE;
          alloc_done_d = 1'b1;
        end
      end
      DEALLOC: begin
        if (lut_v_q[warp_q][k_q]) begin
          mt_d[lut_p_q[warp_q][k_q]] = 1'b0;
          lut_v_d[warp_q][k_q]       = 1'b0;
          avail_d                    = avail_q + AW'(REGS_PER_BLOCK);
        end
        k_d = k_q + LW'(1);
        // Every LUT slot is visited regardless of how many were in use.
        if (int'(k_q) == LUT_DEPTH - 1) begin
          alloc_d[warp_q] = 1'b0;
          state_d         = IDLE;
          exit_done_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alloc_ready = (state_q == IDLE) && !exit_valid;
    exit_ready  = (state_q == IDLE);
    alloc_done  = alloc_done_q;
    alloc_fail  = alloc_fail_q;
    exit_done   = exit_done_q;
    avail_regs  = avail_q;
    lk_hit      = lut_v_q[lk_warp][lk_lblk];
    lk_pblk     = lk_hit ? lut_p_q[lk_warp][lk_lblk] : '0;
    lk_sw_warp  = sw_q[lk_warp];
  end

endmodule

// File: tb/tb_reg_alloc_unit.sv
// Self-checking bench for reg_alloc_unit: directed scenarios plus random
// alloc/exit traffic checked against a transaction-level allocator model.
module tb_reg_alloc_unit;

  localparam int NWARP = 8;
  localparam int NBLK  = 16;
  localparam int RPB   = 2;
  localparam int DEPTH = 4;
  localparam int SWW   = 8;
  localparam int WW    = 3;
  localparam int BW    = 4;
  localparam int LW    = 2;
  localparam int AW    = 6;
  localparam int NW    = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           alloc_valid = 1'b0;
  logic           alloc_ready;
  logic [WW-1:0]  alloc_hw_warp = '0;
  logic [SWW-1:0] alloc_sw_warp = '0;
  logic [NW-1:0]  alloc_nreq = '0;
  logic           alloc_done, alloc_fail;
  logic           exit_valid = 1'b0;
  logic           exit_ready;
  logic [WW-1:0]  exit_warp = '0;
  logic           exit_done;
  logic [WW-1:0]  lk_warp = '0;
  logic [LW-1:0]  lk_lblk = '0;
  logic [BW-1:0]  lk_pblk;
  logic           lk_hit;
  logic [SWW-1:0] lk_sw_warp;
  logic [AW-1:0]  avail_regs;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit m_used [NBLK];
  bit m_v    [NWARP][DEPTH];
  int m_p    [NWARP][DEPTH];
  bit m_al   [NWARP];
  int m_sw   [NWARP];

  reg_alloc_unit #(
    .NUM_WARPS(NWARP), .NUM_BLOCKS(NBLK), .REGS_PER_BLOCK(RPB),
    .LUT_DEPTH(DEPTH), .SWW(SWW)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_hw_warp(alloc_hw_warp), .alloc_sw_warp(alloc_sw_warp),
    .alloc_nreq(alloc_nreq), .alloc_done(alloc_done), .alloc_fail(alloc_fail),
    .exit_valid(exit_valid), .exit_ready(exit_ready), .exit_warp(exit_warp),
    .exit_done(exit_done),
    .lk_warp(lk_warp), .lk_lblk(lk_lblk), .lk_pblk(lk_pblk), .lk_hit(lk_hit),
    .lk_sw_warp(lk_sw_warp), .avail_regs(avail_regs)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_avail();
    int n = 0;
    for (int b = 0; b < NBLK; b++) if (!m_used[b]) n += RPB;
    return n;
  endfunction

  task automatic m_reset();
    for (int b = 0; b < NBLK; b++) m_used[b] = 0;
    for (int w = 0; w < NWARP; w++) begin
      m_al[w] = 0;
      m_sw[w] = 0;
      for (int l = 0; l < DEPTH; l++) begin
        m_v[w][l] = 0;
        m_p[w][l] = 0;
      end
    end
  endtask

  // kind: 3'b100 done, 3'b010 fail, 3'b001 exit_done
  task automatic m_alloc(input int w, input int s, input int n,
                         output logic [2:0] kind, output int lat);
    int nb = (n + RPB - 1) / RPB;
    if (nb == 0) begin
      kind = 3'b100; lat = 1;
    end else if (nb > DEPTH || nb * RPB > m_avail() || m_al[w]) begin
      kind = 3'b010; lat = 1;
    end else begin
      kind = 3'b100; lat = nb + 1;
      m_al[w] = 1;
      m_sw[w] = s;
      for (int k = 0; k < nb; k++) begin
        int b = 0;
        while (m_used[b]) b++;
        m_used[b] = 1;
        m_v[w][k] = 1;
        m_p[w][k] = b;
      end
    end
  endtask

  task automatic m_exit(input int w);
    for (int k = 0; k < DEPTH; k++) begin
      if (m_v[w][k]) begin
        m_used[m_p[w][k]] = 0;
        m_v[w][k] = 0;
      end
    end
    m_al[w] = 0;
  endtask

  task automatic wait_pulse(input string tag, input logic [2:0] exp_kind, input int exp_lat);
    logic [2:0] first = '0;
    logic [2:0] v;
    int lat = -1;
    int cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      v = {alloc_done, alloc_fail, exit_done};
      if (v != 3'b000) begin
        cnt++;
        if (lat < 0) begin
          lat = c;
          first = v;
        end
      end
    end
    check({tag, "_kind"}, 32'(first), 32'(exp_kind));
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_pulses"}, cnt, 1);
  endtask

  task automatic lk_check(input int w, input int l, input int hit, input int pblk);
    lk_warp = WW'(w);
    lk_lblk = LW'(l);
    #1;
    check("lk_hit", 32'(lk_hit), hit);
    check("lk_pblk", 32'(lk_pblk), pblk);
  endtask

  task automatic compare_state();
    check("avail_regs", 32'(avail_regs), m_avail());
    for (int w = 0; w < NWARP; w++) begin
      for (int l = 0; l < DEPTH; l++) begin
        lk_warp = WW'(w);
        lk_lblk = LW'(l);
        #1;
        check("scan_hit", 32'(lk_hit), 32'(m_v[w][l]));
        check("scan_pblk", 32'(lk_pblk), m_v[w][l] ? m_p[w][l] : 0);
      end
      check("scan_sw", 32'(lk_sw_warp), m_sw[w]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    alloc_valid = 1'b0;
    exit_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
    check("rst_pulses", 32'({alloc_done, alloc_fail, exit_done}), 0);
  endtask

  task automatic do_alloc(input int w, input int s, input int n);
    logic [2:0] kind;
    int lat;
    m_alloc(w, s, n, kind, lat);
    @(negedge clk);
    alloc_hw_warp = WW'(w);
    alloc_sw_warp = SWW'(s);
    alloc_nreq    = NW'(n);
    alloc_valid   = 1'b1;
    #1 check("alloc_ready", 32'(alloc_ready), 1);
    @(posedge clk);
    #1 alloc_valid = 1'b0;
    wait_pulse("alloc", kind, lat);
    compare_state();
  endtask

  task automatic do_exit(input int w);
    m_exit(w);
    @(negedge clk);
    exit_warp  = WW'(w);
    exit_valid = 1'b1;
    #1 check("exit_ready", 32'(exit_ready), 1);
    @(posedge clk);
    #1 exit_valid = 1'b0;
    wait_pulse("exit", 3'b001, DEPTH + 1);
    compare_state();
  endtask

  initial begin
    logic [2:0] kind;
    int lat;
    int seen;

    // Reset state
    do_reset();
    check("reset_avail", 32'(avail_regs), 32);
    compare_state();

    // Single allocation, rounding 5 registers up to 3 blocks
    do_alloc(3, 8'h33, 5);
    check("w3_avail", 32'(avail_regs), 26);
    lk_check(3, 0, 1, 0);
    lk_check(3, 1, 1, 1);
    lk_check(3, 2, 1, 2);
    lk_check(3, 3, 0, 0);

    // Rejections: too many blocks, warp already allocated; zero-size request
    do_alloc(0, 1, 9);
    check("fail_avail", 32'(avail_regs), 26);
    do_alloc(3, 2, 2);
    check("realloc_avail", 32'(avail_regs), 26);
    do_alloc(5, 7, 0);

    // Fill the register file, then free one warp and reuse its blocks
    do_reset();
    for (int w = 0; w < 4; w++) do_alloc(w, 16 + w, 8);
    check("full_avail", 32'(avail_regs), 0);
    do_alloc(4, 9, 2);
    do_exit(1);
    check("exit_avail", 32'(avail_regs), 8);
    do_alloc(4, 8'h44, 8);
    for (int k = 0; k < 4; k++) lk_check(4, k, 1, 4 + k);
    do_exit(6);

    // Simultaneous alloc and exit: exit first, alloc taken after exit_done
    @(negedge clk);
    alloc_hw_warp = 3'd1; alloc_sw_warp = 8'h5a; alloc_nreq = 4'd2; alloc_valid = 1'b1;
    exit_warp = 3'd0; exit_valid = 1'b1;
    #1;
    check("both_alloc_ready", 32'(alloc_ready), 0);
    check("both_exit_ready", 32'(exit_ready), 1);
    @(posedge clk);
    #1 exit_valid = 1'b0;
    m_exit(0);
    seen = 0;
    for (int c = 1; c <= 10 && seen == 0; c++) begin
      @(negedge clk);
      if (alloc_done || alloc_fail) seen = -1;
      if (exit_done) seen = c;
    end
    check("both_exit_latency", seen, DEPTH + 1);
    check("both_alloc_ready_after", 32'(alloc_ready), 1);
    m_alloc(1, 8'h5a, 2, kind, lat);
    @(posedge clk);
    #1 alloc_valid = 1'b0;
    wait_pulse("both_alloc", kind, lat);
    compare_state();

    // Reset on the second ALLOC cycle discards the allocation
    do_reset();
    @(negedge clk);
    alloc_hw_warp = 3'd2; alloc_sw_warp = 8'h22; alloc_nreq = 4'd6; alloc_valid = 1'b1;
    @(posedge clk);
    #1 alloc_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (alloc_done) seen++;
    end
    check("rst_mid_no_done", seen, 0);
    check("rst_mid_avail", 32'(avail_regs), 32);
    compare_state();

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) != 0)
        do_alloc($urandom_range(0, NWARP - 1), $urandom_range(0, 255), $urandom_range(0, 15));
      else
        do_exit($urandom_range(0, NWARP - 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
